alien_fire_ctrl: RTL and testbench

ALIEN_FIRE_CTRL -- requirements
Module: alien_fire_ctrl

---
 rtl/alien_fire_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_alien_fire_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_fire_ctrl.sv
// Alien bullet fire controller: picks a random (or aimed) alive column, launches from its
// bottom-most alien once per cooldown. Optional aiming enabled by macro ALIEN_FIRE_AIM_EN.
module alien_fire_ctrl #(
  parameter int          ALIEN_COLS      = 8,
  parameter int          ALIEN_ROWS      = 4,
  parameter int          ALIEN_W         = 32,
  parameter int          ALIEN_H         = 24,
  parameter int          ALIEN_GAP_X     = 16,
  parameter int          ALIEN_GAP_Y     = 12,
  parameter int          COOLDOWN_FRAMES = 60,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                                pixel_clk,
  input  logic                                rst_n,
  input  logic                                fsync,
  input  logic                                enable,
  input  logic [ALIEN_COLS*ALIEN_ROWS-1:0]    alive,
  input  logic signed [11:0]                  group_x,
  input  logic signed [11:0]                  group_y,
  input  logic signed [11:0]                  player_x,
  input  logic                                bullet_active,
  output logic                                fire,
  output logic [11:0]                         alien_x,
  output logic [11:0]                         alien_y
);

  localparam int N      = ALIEN_COLS * ALIEN_ROWS;
  localparam int CW     = $clog2(ALIEN_COLS);
  localparam int RW     = (ALIEN_ROWS > 1) ? $clog2(ALIEN_ROWS) : 1;
  localparam int IW     = $clog2(N);
  localparam int STEP_X = ALIEN_W + ALIEN_GAP_X;
  localparam int STEP_Y = ALIEN_H + ALIEN_GAP_Y;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COOLDOWN,
    ST_SELECT,
    ST_FIRE,
    ST_BUSY
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [CW-1:0]   col_q, col_d;
  logic [CW-1:0]   scan_q, scan_d;
  logic [IW-1:0]   sel_idx_q, sel_idx_d;
  logic            fire_q, fire_d;
  logic [11:0]     alien_x_q, alien_x_d;
  logic [11:0]     alien_y_q, alien_y_d;

  logic [CW-1:0]         rand_col;
  logic [CW-1:0]         start_col;
  logic [ALIEN_COLS-1:0] col_onehot;
  logic [ALIEN_ROWS-1:0] col_bits;
  logic                  col_found;
  logic [RW-1:0]         row_sel;
  logic [IW-1:0]         sel_idx_calc;
  logic [N-1:0]          sel_onehot;
  logic                  alive_sel;
  logic [11:0]           x_calc;
  logic [11:0]           y_calc;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign rand_col = CW'({28'd0, lfsr_q[3:0]} % ALIEN_COLS);

`ifdef ALIEN_FIRE_AIM_EN
  logic          aim_hit;
  logic [CW-1:0] aim_col;

  // Lowest column whose horizontal span covers the player wins.
  always_comb begin
    int left;
    aim_hit = 1'b0;
    aim_col = '0;
    left    = 0;
    for (int c = ALIEN_COLS - 1; c >= 0; c--) begin
      left = int'(group_x) + c * STEP_X;
      if (int'(player_x) >= left && int'(player_x) <= left + ALIEN_W - 1) begin
        aim_hit = 1'b1;
        aim_col = CW'(c);
      end
    end
  end

  assign start_col = aim_hit ? aim_col : rand_col;
`else
  logic unused_player_x;
  assign unused_player_x = ^player_x;
  assign start_col       = rand_col;
`endif

  assign col_onehot = {{(ALIEN_COLS-1){1'b0}}, 1'b1} << col_q;

  // Bottom-most alive alien of the column currently being scanned.
  always_comb begin
    col_found = 1'b0;
    row_sel   = '0;
    col_bits  = '0;
    for (int r = 0; r < ALIEN_ROWS; r++) begin
      col_bits[r] = |(alive[r*ALIEN_COLS +: ALIEN_COLS] & col_onehot);
      if (col_bits[r]) begin
        col_found = 1'b1;
        row_sel   = RW'(r);
      end
    end
  end

  assign sel_idx_calc = IW'(32'(row_sel) * ALIEN_COLS + 32'(col_q));
  assign sel_onehot   = {{(N-1){1'b0}}, 1'b1} << sel_idx_q;
  assign alive_sel    = |(alive & sel_onehot);

  assign x_calc = unsigned'(group_x) + 12'(32'(col_q) * STEP_X + ALIEN_W / 2);
  assign y_calc = unsigned'(group_y) + 12'(32'(row_sel) * STEP_Y + ALIEN_H);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    scan_d    = scan_q;
    sel_idx_d = sel_idx_q;
    fire_d    = fire_q;
    alien_x_d = alien_x_q;
    alien_y_d = alien_y_q;
    unique case (state_q)
      ST_IDLE: begin
        fire_d = 1'b0;
        if (enable && |alive) begin
          state_d = ST_COOLDOWN;
          cnt_d   = 8'(COOLDOWN_FRAMES);
        end
      end
      ST_COOLDOWN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (fsync) begin
          if (cnt_q <= 8'd1) begin
            state_d = ST_SELECT;
            cnt_d   = 8'd0;
            col_d   = start_col;
            scan_d  = '0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_SELECT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (col_found) begin
          state_d   = ST_FIRE;
          fire_d    = 1'b1;
          sel_idx_d = sel_idx_calc;
          alien_x_d = x_calc;
          alien_y_d = y_calc;
        end else if (scan_q == CW'(ALIEN_COLS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          col_d  = (col_q == CW'(ALIEN_COLS - 1)) ? '0 : col_q + 1'b1;
          scan_d = scan_q + 1'b1;
        end
      end
      ST_FIRE: begin
        // A bullet accepted on this edge is already launched, so it beats everything else.
        if (fsync && !bullet_active) begin
          state_d = ST_BUSY;
          fire_d  = 1'b0;
        end else if (!enable) begin
          state_d = ST_IDLE;
          fire_d  = 1'b0;
        end else if (!alive_sel) begin
          state_d = ST_SELECT;
          fire_d  = 1'b0;
          col_d   = start_col;
          scan_d  = '0;
        end
      end
      ST_BUSY: begin
        if (!bullet_active) begin
          if (enable) begin
            state_d = ST_COOLDOWN;
            cnt_d   = 8'(COOLDOWN_FRAMES);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        fire_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      lfsr_q    <= LFSR_SEED;
      col_q     <= '0;
      scan_q    <= '0;
      sel_idx_q <= '0;
      fire_q    <= 1'b0;
      alien_x_q <= 12'd0;
      alien_y_q <= 12'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      col_q     <= col_d;
      scan_q    <= scan_d;
      sel_idx_q <= sel_idx_d;
      fire_q    <= fire_d;
      alien_x_q <= alien_x_d;
      alien_y_q <= alien_y_d;
    end
  end

  assign fire    = fire_q;
  assign alien_x = alien_x_q;
  assign alien_y = alien_y_q;

endmodule

// File: tb/tb_alien_fire_ctrl.sv
// Self-checking bench for alien_fire_ctrl: randomized grids against a rule-level model.
module tb_alien_fire_ctrl;

  localparam int          COLS = 8;
  localparam int          ROWS = 4;
  localparam int          AW   = 32;
  localparam int          AH   = 24;
  localparam int          GPX  = 16;
  localparam int          GPY  = 12;
  localparam int          CD   = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic               pixel_clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               fsync = 1'b0;
  logic               enable = 1'b0;
  logic [31:0]        alive = '0;
  logic signed [11:0] group_x = '0;
  logic signed [11:0] group_y = '0;
  logic signed [11:0] player_x = '0;
  logic               bullet_active = 1'b0;
  logic               fire;
  logic [11:0]        alien_x;
  logic [11:0]        alien_y;

  int n_cmp = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int cur_gx = 0, cur_gy = 0, cur_px = 0;

  alien_fire_ctrl #(
    .ALIEN_COLS(COLS), .ALIEN_ROWS(ROWS), .ALIEN_W(AW), .ALIEN_H(AH),
    .ALIEN_GAP_X(GPX), .ALIEN_GAP_Y(GPY), .COOLDOWN_FRAMES(CD), .LFSR_SEED(SEED)
  ) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .fsync(fsync), .enable(enable),
    .alive(alive), .group_x(group_x), .group_y(group_y), .player_x(player_x),
    .bullet_active(bullet_active), .fire(fire), .alien_x(alien_x), .alien_y(alien_y)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Clock edges since reset release: the LFSR has advanced (edge_cnt-1) times when edge edge_cnt samples.
  always @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] v;
    v = SEED;
    for (int i = 0; i < n; i++) begin
      if (v[0]) v = (v >> 1) ^ 16'hB400;
      else      v = v >> 1;
    end
    return v;
  endfunction

  function automatic int col_has(input logic [31:0] a, input int c);
    int h;
    h = 0;
    for (int r = 0; r < ROWS; r++) if (a[r*COLS + c]) h = 1;
    return h;
  endfunction

  function automatic int bottom_row(input logic [31:0] a, input int c);
    int b;
    b = 0;
    for (int r = 0; r < ROWS; r++) if (a[r*COLS + c]) b = r;
    return b;
  endfunction

  function automatic int start_column(input logic [15:0] lf, input int gx, input int px);
    int s;
    s = int'(lf[3:0]) % COLS;
`ifdef ALIEN_FIRE_AIM_EN
    for (int c = COLS - 1; c >= 0; c--)
      if (px >= gx + c*(AW+GPX) && px <= gx + c*(AW+GPX) + AW - 1) s = c;
`endif
    return s;
  endfunction

  function automatic void model_pick(input logic [31:0] a, input int e,
                                     output int k, output logic [11:0] ex, output logic [11:0] ey);
    int s, c;
    k = -1; ex = '0; ey = '0;
    s = start_column(lfsr_after(e - 1), cur_gx, cur_px);
    for (int i = 0; i < COLS; i++) begin
      c = (s + i) % COLS;
      if (k < 0 && col_has(a, c) != 0) begin
        k  = i;
        ex = 12'(cur_gx + c*(AW+GPX) + AW/2);
        ey = 12'(cur_gy + bottom_row(a, c)*(AH+GPY) + AH);
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge pixel_clk);
  endtask

  task automatic pulse_fsync();
    @(negedge pixel_clk) fsync = 1'b1;
    @(negedge pixel_clk) fsync = 1'b0;
  endtask

  task automatic set_geom(input int gx, input int gy, input int px);
    cur_gx = gx; cur_gy = gy; cur_px = px;
    group_x = 12'(gx); group_y = 12'(gy); player_x = 12'(px);
  endtask

  task automatic arm(output int e, output int early);
    enable = 1'b1;
    early = 0;
    tick(2);
    for (int i = 0; i < CD; i++) begin
      pulse_fsync();
      if (fire) early++;
      if (i < CD - 1) for (int j = 0; j < 3; j++) begin tick(1); if (fire) early++; end
    end
    e = edge_cnt;
  endtask

  task automatic wait_fire(output int w);
    w = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge pixel_clk);
      if (w < 0 && fire === 1'b1) w = i;
      if (w > 0) break;
    end
  endtask

  task automatic count_fire(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin tick(1); if (fire !== 1'b0) seen++; end
  endtask

  task automatic retire_bullet();
    bullet_active = 1'b0;
    pulse_fsync();
    bullet_active = 1'b1;
    tick(4);
    bullet_active = 1'b0;
    tick(2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (fire !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fire: got %0b expected 0", fire); end
    n_cmp++; if (alien_x !== 12'd0) begin n_fail++; $display("[TB] FAIL reset_x: got %0d expected 0", alien_x); end
    n_cmp++; if (alien_y !== 12'd0) begin n_fail++; $display("[TB] FAIL reset_y: got %0d expected 0", alien_y); end
    enable = 1'b1; alive = '1;
    tick(3);
    n_cmp++; if (fire !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_hold_fire: got %0b expected 0", fire); end
    enable = 1'b0;
    @(negedge pixel_clk) rst_n = 1'b1;
  endtask

  task automatic test_random_fire();
    int e, early, k, w;
    logic [11:0] ex, ey;
    for (int it = 0; it < 8; it++) begin
      if (it == 0) alive = '1;
      else begin
        alive = $urandom & $urandom;
        if (alive == 0) alive = 32'd1 << $urandom_range(31, 0);
      end
      set_geom(int'($urandom_range(600, 0)) - 200, int'($urandom_range(500, 0)) - 100,
               int'($urandom_range(450, 0)));
      arm(e, early);
      model_pick(alive, e, k, ex, ey);
      wait_fire(w);
      n_cmp++; if (early !== 0) begin n_fail++; $display("[TB] FAIL early_fire it%0d: got %0d cycles expected 0", it, early); end
      n_cmp++; if (w !== k + 1) begin n_fail++; $display("[TB] FAIL fire_latency it%0d: got %0d expected %0d", it, w, k + 1); end
      n_cmp++; if (alien_x !== ex) begin n_fail++; $display("[TB] FAIL alien_x it%0d: got %0d expected %0d", it, alien_x, ex); end
      n_cmp++; if (alien_y !== ey) begin n_fail++; $display("[TB] FAIL alien_y it%0d: got %0d expected %0d", it, alien_y, ey); end
      bullet_active = 1'b0;
      pulse_fsync();
      n_cmp++; if (fire !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_drop it%0d: got %0b expected 0", it, fire); end
      bullet_active = 1'b1;
      tick(4);
      bullet_active = 1'b0;
      tick(2);
    end
  endtask

  task automatic test_single_alien();
    int e, early, w;
    alive = 32'h0000_0001;
    set_geom(100, 50, 400);
    arm(e, early);
    wait_fire(w);
    n_cmp++; if (w < 0) begin n_fail++; $display("[TB] FAIL single_fire: got no fire expected fire within 20 cycles"); end
    n_cmp++; if (alien_x !== 12'd116) begin n_fail++; $display("[TB] FAIL single_x: got %0d expected 116", alien_x); end
    n_cmp++; if (alien_y !== 12'd74) begin n_fail++; $display("[TB] FAIL single_y: got %0d expected 74", alien_y); end
  endtask

  task automatic test_bullet_hold();
    bullet_active = 1'b1;
    pulse_fsync();
    tick(2);
    n_cmp++; if (fire !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_fire: got %0b expected 1", fire); end
    n_cmp++; if (alien_x !== 12'd116 || alien_y !== 12'd74) begin n_fail++; $display("[TB] FAIL hold_coords: got %0d,%0d expected 116,74", alien_x, alien_y); end
    bullet_active = 1'b0;
    pulse_fsync();
    n_cmp++; if (fire !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_release: got %0b expected 0", fire); end
    bullet_active = 1'b1;
    tick(3);
    bullet_active = 1'b0;
    tick(2);
  endtask

  task automatic test_alive_clear();
    int e, early, w, seen;
    alive = 32'h0000_0101;
    set_geom(20, 10, 400);
    arm(e, early);
    wait_fire(w);
    n_cmp++; if (alien_y !== 12'(10 + 36 + 24)) begin n_fail++; $display("[TB] FAIL clear_bottom_row: got %0d expected %0d", alien_y, 10 + 36 + 24); end
    alive = 32'h0000_0100;
    tick(3);
    n_cmp++; if (fire !== 1'b1) begin n_fail++; $display("[TB] FAIL clear_other_alien: got %0b expected 1", fire); end
    alive = 32'h0;
    tick(1);
    n_cmp++; if (fire !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_drop: got %0b expected 0", fire); end
    count_fire(12, seen);
    n_cmp++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL clear_scan_idle: got %0d fire cycles expected 0", seen); end
    alive = 32'h0000_0100;
    arm(e, early);
    wait_fire(w);
    n_cmp++; if (w < 0) begin n_fail++; $display("[TB] FAIL clear_rearm: got no fire expected fire within 20 cycles"); end
    alive = 32'h0; fsync = 1'b1; bullet_active = 1'b0;
    @(negedge pixel_clk);
    fsync = 1'b0; alive = 32'h0000_0100; bullet_active = 1'b1;
    n_cmp++; if (fire !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_fsync_drop: got %0b expected 0", fire); end
    count_fire(12, seen);
    n_cmp++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL clear_fsync_busy: got %0d fire cycles expected 0", seen); end
    bullet_active = 1'b0;
    tick(2);
  endtask

  task automatic test_empty_scan();
    int e, early, w, seen;
    alive = 32'h0000_0010;
    enable = 1'b1;
    tick(2);
    pulse_fsync(); tick(3);
    pulse_fsync(); tick(3);
    alive = 32'h0;
    pulse_fsync();
    count_fire(15, seen);
    n_cmp++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL empty_scan: got %0d fire cycles expected 0", seen); end
    alive = '1;
    arm(e, early);
    wait_fire(w);
    n_cmp++; if (early !== 0 || w !== 1) begin n_fail++; $display("[TB] FAIL empty_rearm: got early=%0d latency=%0d expected 0 and 1", early, w); end
    retire_bullet();
  endtask

  task automatic test_enable_and_async_reset();
    int e, early, w, seen;
    alive = '1;
    set_geom(40, 30, 400);
    arm(e, early);
    wait_fire(w);
    n_cmp++; if (fire !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset_fire: got %0b expected 1", fire); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (fire !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset_fire: got %0b expected 0", fire); end
    n_cmp++; if (alien_x !== 12'd0 || alien_y !== 12'd0) begin n_fail++; $display("[TB] FAIL async_reset_coords: got %0d,%0d expected 0,0", alien_x, alien_y); end
    @(negedge pixel_clk) rst_n = 1'b1;
    tick(2);
    pulse_fsync(); tick(2);
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(2);
    pulse_fsync(); tick(2);
    pulse_fsync();
    count_fire(12, seen);
    n_cmp++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL cooldown_enable_drop: got %0d fire cycles expected 0", seen); end
    pulse_fsync();
    wait_fire(w);
    n_cmp++; if (w !== 1) begin n_fail++; $display("[TB] FAIL cooldown_reload_fire: got latency %0d expected 1", w); end
    enable = 1'b0;
    tick(1);
    n_cmp++; if (fire !== 1'b0) begin n_fail++; $display("[TB] FAIL fire_enable_drop: got %0b expected 0", fire); end
    count_fire(10, seen);
    n_cmp++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL idle_stays_low: got %0d fire cycles expected 0", seen); end
  endtask

  task automatic test_aim();
    int e, early, k, w;
    logic [11:0] ex, ey;
    alive = 32'h0000_00FF;
    set_geom(0, 0, 200);
    arm(e, early);
    model_pick(alive, e, k, ex, ey);
    wait_fire(w);
    n_cmp++; if (w !== k + 1) begin n_fail++; $display("[TB] FAIL aim_latency: got %0d expected %0d", w, k + 1); end
    n_cmp++; if (alien_x !== ex) begin n_fail++; $display("[TB] FAIL aim_x: got %0d expected %0d", alien_x, ex); end
`ifdef ALIEN_FIRE_AIM_EN
    n_cmp++; if (alien_x !== 12'd208) begin n_fail++; $display("[TB] FAIL aim_column4: got %0d expected 208", alien_x); end
`endif
    retire_bullet();
  endtask

  initial begin
    $display("[TB] alien_fire_ctrl bench start");
    test_reset();
    test_random_fire();
    test_single_alien();
    test_bullet_hold();
    test_alive_clear();
    test_empty_scan();
    test_enable_and_async_reset();
    test_aim();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
